axil_reg_bank: RTL

AXI4-Lite slave register bank that terminates the control-plane master at the `ADDR_REG` window (base `0xA001_2000`). It provides:

- identification and status registers;
- a 64-bit free-running uptime counter with coherent two-word reads;
- a completed-write counter;
- ten byte-strobed scratch registers at offsets `0x18`–`0x3C`.

It accepts write address and write data in either order. Only one write and one read are outstanding at a time.

---
 rtl/axil_reg_pkg.sv | 54 +++++
 rtl/axil_wr_capture.sv | 30 +++
 rtl/axil_reg_bank.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/axil_reg_pkg.sv
// axil_reg_pkg: register offsets, AXI response codes, register-select decode and byte-strobe merge.
// Contents: REG_* byte offsets, NUM_SCRATCH, RESP_OKAY/RESP_SLVERR, reg_sel_t, decode(), apply_strb().
package axil_reg_pkg;
  localparam logic [7:0] REG_VERSION   = 8'h00;
  localparam logic [7:0] REG_CTRL      = 8'h04;
  localparam logic [7:0] REG_STATUS    = 8'h08;
  localparam logic [7:0] REG_UPTIME_LO = 8'h0C;
  localparam logic [7:0] REG_UPTIME_HI = 8'h10;
  localparam logic [7:0] REG_WRCOUNT   = 8'h14;
  localparam logic [7:0] REG_SCRATCH0  = 8'h18;
  localparam logic [7:0] REG_SCRATCH1  = 8'h1C;
  localparam logic [7:0] REG_SCRATCH2  = 8'h20;
  localparam logic [7:0] REG_SCRATCH3  = 8'h24;
  localparam logic [7:0] REG_SCRATCH4  = 8'h28;
  localparam logic [7:0] REG_SCRATCH5  = 8'h2C;
  localparam logic [7:0] REG_SCRATCH6  = 8'h30;
  localparam logic [7:0] REG_SCRATCH7  = 8'h34;
  localparam logic [7:0] REG_SCRATCH8  = 8'h38;
  localparam logic [7:0] REG_SCRATCH9  = 8'h3C;
  localparam int NUM_SCRATCH = 10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SEL_VERSION,
    SEL_CTRL,
    SEL_STATUS,
    SEL_UPTIME_LO,
    SEL_UPTIME_HI,
    SEL_WRCOUNT,
    SEL_SCRATCH,
    SEL_NONE
  } reg_sel_t;

  // w is the word index, i.e. address bits [7:2]
  function automatic reg_sel_t decode(input logic [5:0] w);
    return w == REG_VERSION[7:2]   ? SEL_VERSION
         : w == REG_CTRL[7:2]      ? SEL_CTRL
         : w == REG_STATUS[7:2]    ? SEL_STATUS
         : w == REG_UPTIME_LO[7:2] ? SEL_UPTIME_LO
         : w == REG_UPTIME_HI[7:2] ? SEL_UPTIME_HI
         : w == REG_WRCOUNT[7:2]   ? SEL_WRCOUNT
         : w inside {REG_SCRATCH0[7:2], REG_SCRATCH1[7:2], REG_SCRATCH2[7:2], REG_SCRATCH3[7:2],
                     REG_SCRATCH4[7:2], REG_SCRATCH5[7:2], REG_SCRATCH6[7:2], REG_SCRATCH7[7:2],
                     REG_SCRATCH8[7:2], REG_SCRATCH9[7:2]} ? SEL_SCRATCH
         : SEL_NONE;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    for (int b = 0; b < 4; b++) old_v[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return old_v;
  endfunction
endpackage

// File: rtl/axil_wr_capture.sv
// axil_wr_capture: single-entry holding register with a full flag for one AXI write channel.
// Ports: clk_i, rst_ni (async active-low), load_i (channel handshake), clear_i (write commit),
//        data_i (channel payload), full_o (entry occupied), data_o (held payload).
module axil_wr_capture #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);
  logic         full_q;
  logic [W-1:0] data_q;

  assign full_o = full_q;
  assign data_o = data_q;

  // clear wins over load: a same-cycle handshake on both channels commits straight from the bus
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (load_i) data_q <= data_i;
      full_q <= clear_i ? 1'b0 : (load_i | full_q);
    end
endmodule

// File: rtl/axil_reg_bank.sv
// axil_reg_bank: AXI4-Lite slave register bank (version, ctrl, status, 64-bit uptime, write count, 10 scratch).
// Ports: S_AXI_* AXI4-Lite slave (aclk, async active-low aresetn), ctrl_o (CTRL value),
//        status_i (sampled every cycle into STATUS).
// Option: define AXIL_REG_SLVERR_EN to answer unmapped offsets with SLVERR and not count those writes.
module axil_reg_bank
  import axil_reg_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic                    S_AXI_aclk,
  input  logic                    S_AXI_aresetn,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
  input  logic [2:0]              S_AXI_awprot,
  input  logic                    S_AXI_awvalid,
  output logic                    S_AXI_awready,
  input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
  input  logic                    S_AXI_wvalid,
  output logic                    S_AXI_wready,
  output logic [1:0]              S_AXI_bresp,
  output logic                    S_AXI_bvalid,
  input  logic                    S_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
  input  logic [2:0]              S_AXI_arprot,
  input  logic                    S_AXI_arvalid,
  output logic                    S_AXI_arready,
  output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
  output logic [1:0]              S_AXI_rresp,
  output logic                    S_AXI_rvalid,
  input  logic                    S_AXI_rready,
  output logic [31:0]             ctrl_o,
  input  logic [31:0]             status_i
);
  localparam int SW = DATA_WIDTH / 8;

  logic                  ready_q, bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q, rmux, wd;
  logic [31:0]           ctrl_q, ctrl_d, status_q, shadow_q, wrcnt_q;
  logic [31:0]           scratch_q [NUM_SCRATCH];
  logic [31:0]           scratch_d [NUM_SCRATCH];
  logic [63:0]           uptime_q;
  logic                  aw_hs, w_hs, ar_hs, commit, aw_full, w_full, wr_err, rd_err;
  logic [5:0]            aw_q, wa;
  logic [DATA_WIDTH+SW-1:0] w_q;
  logic [SW-1:0]         ws;
  logic [3:0]            widx, ridx;
  reg_sel_t              wsel, rsel;
  logic                  unused_ok;

  // ready_q keeps every ready low until the first edge after reset release
  assign S_AXI_awready = ready_q & ~aw_full & ~bvalid_q;
  assign S_AXI_wready  = ready_q & ~w_full & ~bvalid_q;
  assign S_AXI_arready = ready_q & ~rvalid_q;
  assign S_AXI_bvalid  = bvalid_q;
  assign S_AXI_bresp   = bresp_q;
  assign S_AXI_rvalid  = rvalid_q;
  assign S_AXI_rresp   = rresp_q;
  assign S_AXI_rdata   = rdata_q;
  assign ctrl_o        = ctrl_q;

  assign aw_hs = S_AXI_awvalid & S_AXI_awready;
  assign w_hs  = S_AXI_wvalid & S_AXI_wready;
  assign ar_hs = S_AXI_arvalid & S_AXI_arready;

  // Same-edge AW+W commits from the bus; otherwise both holders must be full
  assign commit = (aw_hs & w_hs) | (aw_full & w_full);

  axil_wr_capture #(.W(6)) u_aw (
    .clk_i  (S_AXI_aclk),
    .rst_ni (S_AXI_aresetn),
    .load_i (aw_hs),
    .clear_i(commit),
    .data_i (S_AXI_awaddr[7:2]),
    .full_o (aw_full),
    .data_o (aw_q)
  );

  axil_wr_capture #(.W(DATA_WIDTH+SW)) u_w (
    .clk_i  (S_AXI_aclk),
    .rst_ni (S_AXI_aresetn),
    .load_i (w_hs),
    .clear_i(commit),
    .data_i ({S_AXI_wstrb, S_AXI_wdata}),
    .full_o (w_full),
    .data_o (w_q)
  );

  assign wa        = aw_full ? aw_q : S_AXI_awaddr[7:2];
  assign {ws, wd}  = w_full ? w_q : {S_AXI_wstrb, S_AXI_wdata};
  assign wsel      = decode(wa);
  assign widx      = 4'(wa - REG_SCRATCH0[7:2]);
  assign rsel      = decode(S_AXI_araddr[7:2]);
  assign ridx      = 4'(S_AXI_araddr[7:2] - REG_SCRATCH0[7:2]);

`ifdef AXIL_REG_SLVERR_EN
  assign wr_err = wsel == SEL_NONE;
  assign rd_err = rsel == SEL_NONE;
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  // Reads see register values before any same-edge commit
  assign rmux = rsel == SEL_VERSION   ? VERSION
              : rsel == SEL_CTRL      ? ctrl_q
              : rsel == SEL_STATUS    ? status_q
              : rsel == SEL_UPTIME_LO ? uptime_q[31:0]
              : rsel == SEL_UPTIME_HI ? shadow_q
              : rsel == SEL_WRCOUNT   ? wrcnt_q
              : rsel == SEL_SCRATCH   ? scratch_q[ridx]
              : '0;

  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    if (commit && wsel == SEL_CTRL) ctrl_d = apply_strb(ctrl_q, wd, ws);
    if (commit && wsel == SEL_SCRATCH) scratch_d[widx] = apply_strb(scratch_q[widx], wd, ws);
  end

  always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn)
    if (!S_AXI_aresetn) begin
      ready_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      status_q  <= '0;
      shadow_q  <= '0;
      wrcnt_q   <= '0;
      uptime_q  <= '0;
      scratch_q <= '{default: '0};
    end else begin
      ready_q   <= 1'b1;
      uptime_q  <= uptime_q + 64'd1;
      status_q  <= status_i;
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      if (commit && !wr_err) wrcnt_q <= wrcnt_q + 32'd1;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_bready) bvalid_q <= 1'b0;
      if (ar_hs) begin
        rdata_q  <= rmux;
        rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        rvalid_q <= 1'b1;
      end else if (S_AXI_rready) rvalid_q <= 1'b0;
      // LO read snapshots the upper half so a following HI read is coherent with it
      if (ar_hs && rsel == SEL_UPTIME_LO) shadow_q <= uptime_q[63:32];
    end

  assign unused_ok = ^{S_AXI_awprot, S_AXI_arprot, S_AXI_awaddr[ADDR_WIDTH-1:8], S_AXI_awaddr[1:0],
                       S_AXI_araddr[ADDR_WIDTH-1:8], S_AXI_araddr[1:0]};
endmodule
